// File: rtl/lsu_unit_if.sv
// lsu_unit_if: word-bus handshake between the LSU (master) and memory (slave).
// req/we/addr/be/wdata flow master->slave; ack/rdata flow slave->master.
interface lsu_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/lsu_unit.sv
// lsu_unit: MEM-stage load/store unit; one bus transaction per request.
// Ports: clk_i/rst_i, mem_* request in, lsu_* status out, bus master port.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        lsu_fault_o,
  lsu_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        req_q, we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;

  logic        f3_ok, misal, legal, accept, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, fmt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Width decode: unsigned variants exist only for loads.
  always_comb begin
    f3_ok = 1'b0;
    unique case (mem_funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !mem_we_i;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misal = (mem_funct3_i[1:0] == 2'b01 && mem_addr_i[0])
              || (mem_funct3_i[1:0] == 2'b10 && |mem_addr_i[1:0]);
  assign legal = f3_ok && !misal;
  assign accept = (state_q == IDLE) && mem_req_i && legal;
  assign timeout = (cnt_q == TO_LAST);

  // Store lane steering; loads always fetch the full word.
  always_comb begin
    be_d = 4'b1111;
    wdata_d = mem_wdata_i;
    unique case (mem_funct3_i[1:0])
      2'b00: begin
        be_d = 4'b0001 << mem_addr_i[1:0];
        wdata_d = {4{mem_wdata_i[7:0]}};
      end
      2'b01: begin
        be_d = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{mem_wdata_i[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wdata_d = mem_wdata_i;
      end
    endcase
    if (!mem_we_i) be_d = 4'b1111;
  end

  // Load lane select and extension.
  assign lane_b = 8'(bus.rdata >> {off_q, 3'b000});
  assign lane_h = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];

  always_comb begin
    fmt = bus.rdata;
    unique case (f3_q)
      3'b000:  fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  fmt = {24'b0, lane_b};
      3'b101:  fmt = {16'b0, lane_h};
      default: fmt = bus.rdata;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (bus.ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lsu_stall_o = 1'b0;
    lsu_done_o  = 1'b0;
    lsu_fault_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        lsu_stall_o = accept;
        lsu_fault_o = mem_req_i && !legal;
      end
      WAIT:    lsu_stall_o = 1'b1;
      DONE:    lsu_done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      req_q   <= 1'b1;
      we_q    <= mem_we_i;
      err_q   <= 1'b0;
      addr_q  <= {mem_addr_i[31:2], 2'b00};
      wdata_q <= wdata_d;
      rdata_q <= '0;
      be_q    <= be_d;
      f3_q    <= mem_funct3_i;
      off_q   <= mem_addr_i[1:0];
      cnt_q   <= '0;
    end else if (state_q == WAIT) begin
      if (bus.ack) begin
        req_q   <= 1'b0;
        rdata_q <= we_q ? 32'b0 : fmt;
      end else if (timeout) begin
        req_q   <= 1'b0;
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.req     = req_q;
  assign bus.we      = we_q;
  assign bus.addr    = addr_q;
  assign bus.be      = be_q;
  assign bus.wdata   = wdata_q;
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed vectors plus wait-state, timeout and reset sequences.
// Built with TIMEOUT_CYCLES=4 so the timeout path is short.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  mem_f3 = 3'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        stall, done, err, fault;
  logic [31:0] rdata;

  int total = 0;
  int bad = 0;

  lsu_unit_if bus ();

  lsu_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_req_i    (mem_req),
    .mem_we_i     (mem_we),
    .mem_funct3_i (mem_f3),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .lsu_stall_o  (stall),
    .lsu_done_o   (done),
    .lsu_rdata_o  (rdata),
    .lsu_err_o    (err),
    .lsu_fault_o  (fault),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brd;
    logic        flt;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[12];

  function automatic vec_t mk(
    input logic we, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] brd, input logic flt,
    input logic [31:0] baddr, input logic [3:0] be,
    input logic [31:0] bwd, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd;
    v.brd = brd; v.flt = flt; v.baddr = baddr; v.be = be;
    v.bwd = bwd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_req = 1'b1;
    mem_we = we;
    mem_f3 = f3;
    mem_addr = a;
    mem_wdata = wd;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    string s;
    s = $sformatf("v%0d", k);
    drive(v.we, v.f3, v.addr, v.wdata);
    #1;
    chk({s, "_c0_fault"}, 32'(fault), 32'(v.flt));
    chk({s, "_c0_stall"}, 32'(stall), 32'(!v.flt));
    if (v.flt) begin
      tick();
      mem_req = 1'b0;
      #1;
      chk({s, "_noreq"}, 32'(bus.req), 32'd0);
      chk({s, "_nodone"}, 32'(done), 32'd0);
    end else begin
      tick();
      bus.ack = 1'b1;
      bus.rdata = v.brd;
      #1;
      chk({s, "_c1_req"}, 32'(bus.req), 32'd1);
      chk({s, "_c1_stall"}, 32'(stall), 32'd1);
      chk({s, "_addr"}, bus.addr, v.baddr);
      chk({s, "_be"}, 32'(bus.be), 32'(v.be));
      chk({s, "_we"}, 32'(bus.we), 32'(v.we));
      if (v.we) chk({s, "_wdata"}, bus.wdata, v.bwd);
      tick();
      bus.ack = 1'b0;
      #1;
      chk({s, "_c2_done"}, 32'(done), 32'd1);
      chk({s, "_c2_stall"}, 32'(stall), 32'd0);
      chk({s, "_c2_req"}, 32'(bus.req), 32'd0);
      chk({s, "_rdata"}, rdata, v.rd);
      chk({s, "_err"}, 32'(err), 32'd0);
      tick();
      mem_req = 1'b0;
      #1;
      chk({s, "_c3_done"}, 32'(done), 32'd0);
      chk({s, "_c3_noretrig"}, 32'(bus.req), 32'd0);
    end
  endtask

  initial begin
    bus.ack = 1'b0;
    bus.rdata = '0;

    tv[0]  = mk(0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0,
                32'h100, 4'b1111, 0, 32'hFFFF_FF80);
    tv[1]  = mk(1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h1111_1111, 0,
                32'h200, 4'b1100, 32'hABCD_ABCD, 0);
    tv[2]  = mk(1, 3'b000, 32'h201, 32'h55, 32'h2222_2222, 0,
                32'h200, 4'b0010, 32'h5555_5555, 0);
    tv[3]  = mk(0, 3'b101, 32'h2, 0, 32'h9876_0000, 0,
                32'h0, 4'b1111, 0, 32'h0000_9876);
    tv[4]  = mk(0, 3'b001, 32'h2, 0, 32'h9876_0000, 0,
                32'h0, 4'b1111, 0, 32'hFFFF_9876);
    tv[5]  = mk(0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0,
                32'h100, 4'b1111, 0, 32'hDEAD_BEEF);
    tv[6]  = mk(0, 3'b100, 32'h101, 0, 32'h80FF_1234, 0,
                32'h100, 4'b1111, 0, 32'h0000_0012);
    tv[7]  = mk(1, 3'b010, 32'h300, 32'h1234_5678, 32'h0, 0,
                32'h300, 4'b1111, 32'h1234_5678, 0);
    tv[8]  = mk(0, 3'b010, 32'h102, 0, 0, 1, 0, 0, 0, 0);
    tv[9]  = mk(0, 3'b011, 32'h100, 0, 0, 1, 0, 0, 0, 0);
    tv[10] = mk(1, 3'b001, 32'h201, 32'h1234, 0, 1, 0, 0, 0, 0);
    tv[11] = mk(1, 3'b100, 32'h200, 32'h12, 0, 1, 0, 0, 0, 0);

    #1;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_be", 32'(bus.be), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(i, tv[i]);

    // Two slave wait states: stall C0..C3, done in C4.
    drive(0, 3'b010, 32'h400, 0);
    #1;
    chk("ws_c0_stall", 32'(stall), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin
        bus.ack = 1'b1;
        bus.rdata = 32'hCAFE_F00D;
      end
      #1;
      chk($sformatf("ws_c%0d_stall", c), 32'(stall), 32'd1);
      chk($sformatf("ws_c%0d_done", c), 32'(done), 32'd0);
    end
    tick();
    bus.ack = 1'b0;
    #1;
    chk("ws_c4_done", 32'(done), 32'd1);
    chk("ws_c4_stall", 32'(stall), 32'd0);
    chk("ws_c4_rdata", rdata, 32'hCAFE_F00D);
    tick();
    mem_req = 1'b0;
    #1;

    // Timeout: four WAIT cycles with no ack.
    bus.rdata = 32'hFFFF_FFFF;
    drive(0, 3'b010, 32'h500, 0);
    #1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      chk($sformatf("to_w%0d_req", c), 32'(bus.req), 32'd1);
      chk($sformatf("to_w%0d_stall", c), 32'(stall), 32'd1);
    end
    tick();
    #1;
    chk("to_req", 32'(bus.req), 32'd0);
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", rdata, 32'd0);
    chk("to_stall", 32'(stall), 32'd0);
    tick();
    mem_req = 1'b0;
    #1;

    // Reset while WAIT: req drops at once, no done pulse.
    drive(0, 3'b010, 32'h600, 0);
    tick();
    #1;
    chk("rw_req_before", 32'(bus.req), 32'd1);
    rst = 1'b1;
    mem_req = 1'b0;
    #1;
    chk("rw_req_async", 32'(bus.req), 32'd0);
    chk("rw_done_async", 32'(done), 32'd0);
    tick();
    chk("rw_done_hold", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk("rw_done_after", 32'(done), 32'd0);

    // Ack while IDLE must not start or finish anything.
    bus.ack = 1'b1;
    bus.rdata = 32'h1234_5678;
    #1;
    chk("ia_stall", 32'(stall), 32'd0);
    tick();
    bus.ack = 1'b0;
    #1;
    chk("ia_done", 32'(done), 32'd0);
    chk("ia_req", 32'(bus.req), 32'd0);
    chk("ia_rdata", rdata, 32'd0);

    run_vec(12, mk(0, 3'b010, 32'h600, 0, 32'h0BAD_F00D, 0,
                   32'h600, 4'b1111, 0, 32'h0BAD_F00D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit for the RV32I core's MEM stage. It turns a load or store request from the pipeline into one handshaked word-bus transaction. Stores get byte-lane steering and byte enables. Loads get lane selection and sign/zero extension, and the result feeds the load-data input of the writeback select mux. While a transaction is outstanding it stalls the pipeline. It flags misaligned accesses, illegal width codes and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 255: number of WAIT cycles without `bus_ack_i` before the transaction is aborted (range 1..255).
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- mem_req_i  input  1  MEM-stage instruction is a load/store; held high by the pipeline while `lsu_stall_o`=1.
- mem_we_i  input  1  1=store, 0=load.
- mem_funct3_i  input  3  RV32I width code.
- mem_addr_i  input  32  byte address.
- mem_wdata_i  input  32  store data (rs2).
- lsu_stall_o  output  1  freeze PC/IF/ID/EX/MEM (combinational).
- lsu_done_o  output  1  one-cycle pulse: transaction finished; `lsu_rdata_o`/`lsu_err_o` valid.
- lsu_rdata_o  output  32  formatted load data; 0 for stores and errors.
- lsu_err_o  output  1  bus timeout; valid with `lsu_done_o`.
- lsu_fault_o  output  1  one-cycle pulse: misaligned address or illegal funct3; no bus access made.
- bus_req_o  output  1  bus request (registered).
- bus_we_o  output  1  bus write.
- bus_addr_o  output  32  word address: {addr[31:2],2'b00}.
- bus_be_o  output  4  byte enables (stores; 4'b1111 on loads).
- bus_wdata_o  output  32  lane-steered store data.
- bus_ack_i  input  1  slave completion; read data valid in the same cycle.
- bus_rdata_i  input  32  read data word.

## Operation
- Three states: IDLE, WAIT, DONE.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Misaligned accesses: halfword with addr[0]=1; word with addr[1:0]≠0.
- IDLE with mem_req_i=1 and the request faulty:
  - Pulse `lsu_fault_o` in that cycle (combinational).
  - `lsu_stall_o`=0 and the state stays IDLE.
  - The pipeline handles the trap.
- IDLE with mem_req_i=1 and the request legal:
  - Latch the request fields.
  - Drive `bus_addr_o`, `bus_we_o`, `bus_be_o` and `bus_wdata_o` from the latched fields.
  - Set `bus_req_o`=1 and go to WAIT.
- Store steering:
  - SB: be=4'b0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated ×2.
  - SW: be=4'b1111; wdata unchanged.
- WAIT:
  - `bus_req_o` and all bus fields are held stable.
  - The timeout counter increments each cycle.
  - On `bus_ack_i`=1: register the formatted read data, clear `bus_req_o`, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no ack: clear `bus_req_o`, set the error flag, rdata=0, go to DONE.
- Load formatting: select lane addr[1:0] (byte) or addr[1] (halfword) from `bus_rdata_i`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- DONE:
  - `lsu_done_o`=1 and `lsu_stall_o`=0, so the pipeline advances.
  - Next state is always IDLE. The `mem_req_i` seen in DONE is the finished request and must not re-trigger.
- Stall equation: `lsu_stall_o` = (IDLE & mem_req_i & legal) | WAIT.
- `bus_ack_i` in IDLE or DONE is ignored.
- Reset:
  - All registered outputs go to 0 and the state goes to IDLE immediately.
  - `bus_req_o` drops asynchronously, including mid-WAIT.
  - The in-flight access is abandoned with no done pulse.

## Timing
- Reset values: bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_be_o=0, bus_wdata_o=0, lsu_rdata_o=0, lsu_done_o=0, lsu_err_o=0. lsu_stall_o and lsu_fault_o are 0 while mem_req_i=0.
- Minimum transaction, zero-wait slave:
  - C0: IDLE accepts, stall=1.
  - C1: WAIT, bus_req_o=1, ack=1, stall=1.
  - C2: DONE, done=1, stall=0.
  - Total latency is 3 cycles, with 2 stall cycles.
- Each wait cycle the slave inserts adds one stall cycle.
- Timeout: DONE is reached after exactly TIMEOUT_CYCLES WAIT cycles, with lsu_err_o=1.
- Back-to-back accesses: a new request can be accepted in the cycle after DONE, so the rate is 1 access per 3 cycles minimum.
- The next-state path is never combinational through bus_ack_i into the bus_* outputs.

## Test plan
- **LB sign extension:** LB, addr=0x103, bus_rdata=0x80FF_1234, ack in C1 → bus_addr=0x100, be=4'b1111; C2 done=1, rdata=0xFFFF_FF80; stall high C0–C1 only.
- **Store steering:** SH, addr=0x202, wdata=0x0000_ABCD → bus_be=4'b1100, bus_wdata=0xABCD_ABCD, bus_we=1. SB, addr=0x201, wdata=0x55 → be=4'b0010, wdata=0x5555_5555.
- **Zero extension:** LHU, addr=0x2, rdata=0x9876_0000 → 0x0000_9876. LH on the same word → 0xFFFF_9876.
- **Faults:** LW at 0x102 → fault pulse in C0, no bus_req, stall=0. funct3=3'b011 load → same response.
- **Slave wait states and timeout:** ack after 3 wait cycles → stall high 4 cycles, done in the 5th. TIMEOUT_CYCLES=4 with no ack → bus_req drops after 4 WAIT cycles, done=1, err=1, rdata=0.
- **Reset mid-WAIT:** assert rst_i while bus_req_o=1 → bus_req_o=0 immediately, no done pulse. After release, a new LW completes normally. An ack arriving in IDLE is ignored.
